// File: rtl/display_pkg.sv
// Shared display constants: FSM state codes and default panel geometry
// used by the loader, driver, memory and colour encoder.
package display_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_FLIP = 2'd2;

  localparam int DEFAULT_ROWS            = 8;
  localparam int DEFAULT_COLUMNS         = 32;
  localparam int DEFAULT_BYTES_PER_PIXEL = 3;
  localparam int DEFAULT_BITDEPTH        = 8 * DEFAULT_BYTES_PER_PIXEL;

  function automatic int frame_pixels(input int n_rows, input int n_cols);
    return n_rows * n_cols;
  endfunction

endpackage

// File: rtl/pixel_assembler.sv
// Collects bytes MSB-first into one pixel; start_i forces the byte to be
// byte 0 of a fresh pixel regardless of any partial pixel in progress.
module pixel_assembler #(
  parameter int BYTES = 3,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid_i,
  input  logic             start_i,
  input  logic [7:0]       data_i,
  output logic [WIDTH-1:0] pixel_o,
  output logic             pixel_valid_o
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx;

  always_comb begin
    idx           = start_i ? '0 : cnt_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    pixel_valid_o = 1'b0;
    if (byte_valid_i) begin
      // Older bytes move up, so byte 0 ends in the top byte lane.
      shift_d = WIDTH'({shift_q, data_i});
      if (idx == CNT_W'(BYTES - 1)) begin
        cnt_d         = '0;
        pixel_valid_o = 1'b1;
      end else begin
        cnt_d = idx + 1'b1;
      end
    end
  end

  assign pixel_o = shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Writes assembled pixels row-major into the back buffer, then holds a flip
// request until the driver signals a safe frame boundary.
module frame_loader
  import display_pkg::*;
#(
  parameter int rows            = DEFAULT_ROWS,
  parameter int columns         = DEFAULT_COLUMNS,
  parameter int bytes_per_pixel = DEFAULT_BYTES_PER_PIXEL,
  parameter int width           = DEFAULT_BITDEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 data,
  input  logic                       valid,
  input  logic                       sot,
  input  logic                       eot,
  input  logic                       safe_flip,
  output logic                       wen,
  output logic [$clog2(rows)-1:0]    wrow,
  output logic [$clog2(columns)-1:0] wcol,
  output logic [width-1:0]           wdata,
  output logic                       flip,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       short_frame
);

  localparam int TOTAL = frame_pixels(rows, columns);
  localparam int RW    = $clog2(rows);
  localparam int CW    = $clog2(columns);
  localparam int PW    = $clog2(TOTAL + 1);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             wen_q, wen_d;
  logic [RW-1:0]    wrow_q, wrow_d;
  logic [CW-1:0]    wcol_q, wcol_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic             flip_q, flip_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             short_q, short_d;

  logic             in_load;
  logic             accept;
  logic             start;
  logic [width-1:0] pixel;
  logic             pixel_valid;

  assign in_load = (state_q == ST_LOAD);
  assign accept  = valid && ((state_q == ST_IDLE && sot) || in_load);
  assign start   = accept && sot;

  pixel_assembler #(
    .BYTES (bytes_per_pixel),
    .WIDTH (width)
  ) u_asm (
    .clk           (clk),
    .rst           (rst),
    .byte_valid_i  (accept),
    .start_i       (start),
    .data_i        (data),
    .pixel_o       (pixel),
    .pixel_valid_o (pixel_valid)
  );

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    row_d   = row_q;
    col_d   = col_q;
    wen_d   = 1'b0;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    wdata_d = wdata_q;
    flip_d  = flip_q;
    done_d  = 1'b0;
    short_d = 1'b0;

    if (start) begin
      state_d = ST_LOAD;
      pcnt_d  = '0;
      row_d   = '0;
      col_d   = '0;
    end

    // Once the frame is full, further pixels are dropped without wrapping.
    if (pixel_valid && pcnt_d != PW'(TOTAL)) begin
      wen_d   = 1'b1;
      wrow_d  = row_d;
      wcol_d  = col_d;
      wdata_d = pixel;
      pcnt_d  = pcnt_d + 1'b1;
      if (col_d == CW'(columns - 1)) begin
        col_d = '0;
        row_d = row_d + 1'b1;
      end else begin
        col_d = col_d + 1'b1;
      end
    end

    // Uses the post-write count so a final pixel coinciding with eot counts.
    if (in_load && eot) begin
      if (pcnt_d == PW'(TOTAL)) begin
        state_d = ST_WAIT_FLIP;
      end else begin
        short_d = 1'b1;
        state_d = ST_IDLE;
      end
    end

    if (state_q == ST_WAIT_FLIP && safe_flip) begin
      flip_d  = ~flip_q;
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wen_q   <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      wdata_q <= '0;
      flip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wen_q   <= wen_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      wdata_q <= wdata_d;
      flip_q  <= flip_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      short_q <= short_d;
    end
  end

  assign wen         = wen_q;
  assign wrow        = wrow_q;
  assign wcol        = wcol_q;
  assign wdata       = wdata_q;
  assign flip        = flip_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: a byte-count frame model checked every
// cycle, plus literal expectations per scenario.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic        sot = 1'b0;
  logic        eot = 1'b0;
  logic        safe_flip = 1'b0;
  logic        wen;
  logic [2:0]  wrow;
  logic [4:0]  wcol;
  logic [23:0] wdata;
  logic        flip;
  logic        busy;
  logic        frame_done;
  logic        short_frame;

  int vectors = 0;
  int miscompares = 0;

  frame_loader #(
    .rows            (8),
    .columns         (32),
    .bytes_per_pixel (3),
    .width           (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .valid       (valid),
    .sot         (sot),
    .eot         (eot),
    .safe_flip   (safe_flip),
    .wen         (wen),
    .wrow        (wrow),
    .wcol        (wcol),
    .wdata       (wdata),
    .flip        (flip),
    .busy        (busy),
    .frame_done  (frame_done),
    .short_frame (short_frame)
  );

  always #5 clk = ~clk;

  // Model: a frame is a byte stream; pixel n completes with byte 3n+2.
  int          m_mode = 0;   // 0 idle, 1 loading, 2 waiting for flip
  int          m_nbytes = 0;
  logic [23:0] m_sr = '0;
  logic        m_wen = 1'b0, m_flip = 1'b0, m_done = 1'b0, m_short = 1'b0;
  int          m_row = 0, m_col = 0;
  logic [23:0] m_wdata = '0;

  task automatic model_byte(input logic [7:0] b);
    int idx;
    m_sr = {m_sr[15:0], b};
    m_nbytes++;
    if (m_nbytes % 3 == 0 && m_nbytes <= 768) begin
      idx     = m_nbytes / 3 - 1;
      m_wen   = 1'b1;
      m_row   = idx / 32;
      m_col   = idx % 32;
      m_wdata = m_sr;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_nbytes = 0; m_sr = '0;
      m_wen = 1'b0; m_flip = 1'b0; m_done = 1'b0; m_short = 1'b0;
    end else begin
      m_wen = 1'b0; m_done = 1'b0; m_short = 1'b0;
      if (m_mode == 0) begin
        if (valid && sot) begin
          m_mode = 1; m_nbytes = 0; model_byte(data);
        end
      end else if (m_mode == 1) begin
        if (valid) begin
          if (sot) m_nbytes = 0;
          model_byte(data);
        end
        if (eot) begin
          if (m_nbytes / 3 >= 256) m_mode = 2;
          else begin m_short = 1'b1; m_mode = 0; end
        end
      end else if (safe_flip) begin
        m_flip = ~m_flip; m_done = 1'b1; m_mode = 0;
      end
    end
  end

  // Per-scenario write statistics gathered from the DUT.
  int          wen_count = 0, short_count = 0, done_count = 0;
  int          last_row = -1, last_col = -1;
  logic [23:0] last_wdata = '0;
  logic [23:0] mem_seen [256];
  bit          cmp_en = 1'b0;

  initial forever begin
    @(negedge clk);
    if (wen) begin
      wen_count++;
      last_row = int'(wrow); last_col = int'(wcol); last_wdata = wdata;
      mem_seen[{wrow, wcol}] = wdata;
    end
    if (short_frame) short_count++;
    if (frame_done) done_count++;
    if (cmp_en) begin
      vectors++;
      if (wen !== m_wen || flip !== m_flip || busy !== (m_mode != 0) ||
          frame_done !== m_done || short_frame !== m_short ||
          (m_wen && (int'(wrow) != m_row || int'(wcol) != m_col || wdata !== m_wdata))) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t got wen=%b r=%0d c=%0d d=%h flip=%b busy=%b done=%b short=%b want wen=%b r=%0d c=%0d d=%h flip=%b busy=%b done=%b short=%b",
                 $time, wen, wrow, wcol, wdata, flip, busy, frame_done, short_frame,
                 m_wen, m_row, m_col, m_wdata, m_flip, (m_mode != 0), m_done, m_short);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    wen_count = 0; short_count = 0; done_count = 0;
    last_row = -1; last_col = -1; last_wdata = '0;
    for (int i = 0; i < 256; i++) mem_seen[i] = 24'hxxxxxx;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    valid = 1'b1; data = b; sot = s;
    @(posedge clk); #1;
    valid = 1'b0; sot = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int k = 0; k < n; k++) send_byte(k[7:0], k == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_eot();
    eot = 1'b1; @(posedge clk); #1; eot = 1'b0;
  endtask

  task automatic pulse_safe();
    safe_flip = 1'b1; @(posedge clk); #1; safe_flip = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {28'd0, wen, wrow, wcol, wdata, flip, busy, frame_done, short_frame};
  endfunction

  initial begin
    #2 rst = 1'b1;
    #1 check("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    idle(2);

    // Full frame, safe_flip five cycles after eot.
    clear_stats();
    send_frame(768);
    pulse_eot();
    idle(4);
    check("full_busy_wait", {63'd0, busy}, 64'd1);
    safe_flip = 1'b1; @(posedge clk); #1;
    check("full_flip", {63'd0, flip}, 64'd1);
    check("full_done", {63'd0, frame_done}, 64'd1);
    safe_flip = 1'b0;
    idle(2);
    check("full_wen_count", 64'(wen_count), 64'd256);
    check("full_pix00", {40'd0, mem_seen[0]}, 64'h000102);
    check("full_pix731", {40'd0, mem_seen[255]}, 64'hFDFEFF);
    $display("txn full_frame: writes=%0d flip=%b", wen_count, flip);

    // Short frame of 100 bytes.
    clear_stats();
    send_frame(100);
    pulse_eot();
    idle(2);
    check("short_wen_count", 64'(wen_count), 64'd33);
    check("short_last_addr", {32'(last_row), 32'(last_col)}, {32'd1, 32'd0});
    check("short_pulses", 64'(short_count), 64'd1);
    check("short_flip_busy", {62'd0, flip, busy}, {62'd0, 1'b1, 1'b0});
    $display("txn short_frame: writes=%0d short=%0d", wen_count, short_count);

    // Flip wait with traffic that must be ignored.
    send_frame(768);
    pulse_eot();
    clear_stats();
    for (int i = 0; i < 40; i++) begin
      valid = (i < 10); data = 8'(8'h50 + i); sot = (i == 3); eot = (i == 7);
      @(posedge clk); #1;
      if (i == 39) check("wait_busy", {63'd0, busy}, 64'd1);
    end
    valid = 1'b0; sot = 1'b0; eot = 1'b0;
    check("wait_no_wen", 64'(wen_count), 64'd0);
    check("wait_flip_held", {63'd0, flip}, 64'd1);
    pulse_safe();
    check("wait_flip_toggled", {62'd0, flip, frame_done}, {62'd0, 1'b0, 1'b1});
    $display("txn flip_wait: flip=%b", flip);
    idle(2);

    // Mid-frame restart.
    send_frame(50);
    clear_stats();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    idle(1);
    check("restart_count", 64'(wen_count), 64'd1);
    check("restart_write", {16'(last_row), 16'(last_col), 8'd0, last_wdata},
          {16'd0, 16'd0, 8'd0, 24'hAABBCC});
    pulse_eot();
    idle(2);
    $display("txn restart: wdata=%h", last_wdata);

    // Overflow: six bytes beyond the frame.
    clear_stats();
    send_frame(774);
    idle(1);
    check("ovf_wen_count", 64'(wen_count), 64'd256);
    check("ovf_last_addr", {32'(last_row), 32'(last_col)}, {32'd7, 32'd31});
    pulse_eot();
    safe_flip = 1'b1; @(posedge clk); #1; safe_flip = 1'b0;
    check("ovf_flip", {62'd0, flip, frame_done}, {62'd0, 1'b1, 1'b1});
    idle(2);
    $display("txn overflow: writes=%0d flip=%b", wen_count, flip);

    // Asynchronous reset during LOAD, then during WAIT_FLIP.
    send_frame(120);
    #2 rst = 1'b1;
    #1 check("rst_in_load", all_outs(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);
    send_frame(768);
    pulse_eot();
    idle(3);
    check("pre_rst_wait_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1 check("rst_in_wait", all_outs(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);
    clear_stats();
    send_frame(768);
    pulse_eot();
    pulse_safe();
    check("post_rst_flip", {62'd0, flip, frame_done}, {62'd0, 1'b1, 1'b1});
    check("post_rst_count", 64'(wen_count), 64'd256);
    check("post_rst_pix00", {40'd0, mem_seen[0]}, 64'h000102);
    $display("txn reset_reload: writes=%0d flip=%b", wen_count, flip);
    idle(3);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
